// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared types and helpers for the drive arbiter:
//   dir_t            - 4-bit direction code understood by the motor driver
//   state_t          - arbiter FSM states
//   src_t            - active-source code reported on the src output
//   MAN_*            - Arduino manual drive byte values
//   man_byte_to_dir  - manual byte -> dir_t (unknown bytes map to STOP)
//   auto_code_to_dir - planner code -> dir_t (out-of-range codes map to STOP)
//   obstacle_filter  - suppresses forward-moving directions while blocked
// -----------------------------------------------------------------------------
package drive_pkg;

  typedef enum logic [3:0] {
    DIR_STOP  = 4'd0,
    DIR_FWD   = 4'd1,
    DIR_BWD   = 4'd2,
    DIR_LEFT  = 4'd3,
    DIR_RIGHT = 4'd4,
    DIR_LF    = 4'd5,
    DIR_RF    = 4'd6,
    DIR_LB    = 4'd7,
    DIR_RB    = 4'd8
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HANDOVER,
    ST_MANUAL,
    ST_AUTO,
    ST_TIMEOUT
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_MANUAL = 2'd1,
    SRC_AUTO   = 2'd2
  } src_t;

  localparam logic [7:0] MAN_STOP    = 8'h00;
  localparam logic [7:0] MAN_FWD     = 8'h01;
  localparam logic [7:0] MAN_FWD_ALT = 8'h0A;
  localparam logic [7:0] MAN_BWD     = 8'h04;
  localparam logic [7:0] MAN_LEFT    = 8'h02;
  localparam logic [7:0] MAN_RIGHT   = 8'h08;
  localparam logic [7:0] MAN_LF      = 8'h03;
  localparam logic [7:0] MAN_RF      = 8'h09;
  localparam logic [7:0] MAN_LB      = 8'h06;
  localparam logic [7:0] MAN_RB      = 8'h0C;

  function automatic dir_t man_byte_to_dir(input logic [7:0] b);
    dir_t d;
    case (b)
      MAN_FWD, MAN_FWD_ALT: d = DIR_FWD;
      MAN_BWD:              d = DIR_BWD;
      MAN_LEFT:             d = DIR_LEFT;
      MAN_RIGHT:            d = DIR_RIGHT;
      MAN_LF:               d = DIR_LF;
      MAN_RF:               d = DIR_RF;
      MAN_LB:               d = DIR_LB;
      MAN_RB:               d = DIR_RB;
      default:              d = DIR_STOP;
    endcase
    return d;
  endfunction

  function automatic dir_t auto_code_to_dir(input logic [3:0] c);
    dir_t d;
    if (c > 4'd8) d = DIR_STOP;
    else          d = dir_t'(c);
    return d;
  endfunction

  function automatic dir_t obstacle_filter(input dir_t d, input logic obs);
    dir_t r;
    r = d;
    if (obs && (d == DIR_FWD || d == DIR_LF || d == DIR_RF)) r = DIR_STOP;
    return r;
  endfunction

endpackage

// File: rtl/drive_watchdog.sv
// -----------------------------------------------------------------------------
// drive_watchdog
// Counts consecutive cycles without a kick while armed. Holding load_i clears
// the count (used while the arbiter is not in MANUAL, so every entry to
// MANUAL starts a fresh window). The counter saturates instead of wrapping.
// expire_o asserts in the TIMEOUT_CYCLES-th consecutive cycle without a kick,
// so the consumer changes state right after that many silent cycles. A kick
// in the same cycle masks expiry.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - clear and hold the count (watchdog disarmed)
//   kick_i      - link activity; clears the count
//   expire_o    - silence window elapsed (combinational)
// -----------------------------------------------------------------------------
module drive_watchdog #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] CNT_MAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] CNT_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || kick_i)    cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = !load_i && !kick_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/drive_arbiter.sv
// -----------------------------------------------------------------------------
// drive_arbiter
// Chooses between manual Arduino drive bytes and autonomous planner codes,
// inserting a brake interval (HANDOVER) on every source switch and stopping
// the robot when the manual link goes silent (TIMEOUT).
// Optional build macro: OBSTACLE_STOP_EN - while obstacle is high, FWD/LF/RF
// are replaced by STOP in MANUAL and AUTO. Without it, obstacle is ignored.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   manual_on           - 1 selects manual source, 0 selects autonomous
//   man_cmd, man_valid  - manual drive byte and its one-cycle strobe
//   auto_dir, auto_valid- planner direction code and its level qualifier
//   auto_ready          - high while in AUTO
//   obstacle            - obstacle-ahead flag
//   drive_dir, drive_en - direction and enable to the motor driver
//   src                 - active source: 0 none, 1 manual, 2 auto
//   fault               - manual watchdog expired
// All outputs are registered and track the registered state.
// -----------------------------------------------------------------------------
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       manual_on,
  input  logic [7:0] man_cmd,
  input  logic       man_valid,
  input  logic [3:0] auto_dir,
  input  logic       auto_valid,
  output logic       auto_ready,
  input  logic       obstacle,
  output logic [3:0] drive_dir,
  output logic       drive_en,
  output logic [1:0] src,
  output logic       fault
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic          target_man_q, target_man_d;
  logic [HW-1:0] hold_q, hold_d;
  dir_t          dir_q, dir_d;
  logic          en_q, en_d;
  src_t          src_q, src_d;
  logic          fault_q, fault_d;
  logic          rdy_q, rdy_d;

  logic wd_load, wd_kick, wd_expire;
  logic obs_active;
  dir_t man_dir, auto_dir_s;

`ifdef OBSTACLE_STOP_EN
  assign obs_active = obstacle;
`else
  logic unused_obstacle;
  assign unused_obstacle = obstacle;
  assign obs_active      = 1'b0;
`endif

  assign man_dir    = man_byte_to_dir(man_cmd);
  assign auto_dir_s = auto_valid ? auto_code_to_dir(auto_dir) : DIR_STOP;

  // Watchdog only runs in MANUAL; a strobe arriving together with a
  // manual_on drop is discarded, so it must not count as a kick either.
  assign wd_load = (state_q != ST_MANUAL);
  assign wd_kick = man_valid && manual_on;

  drive_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (wd_load),
    .kick_i  (wd_kick),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    target_man_d = target_man_q;
    hold_d       = hold_q;
    dir_d        = dir_q;
    en_d         = 1'b0;
    src_d        = SRC_NONE;
    fault_d      = 1'b0;
    rdy_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d      = ST_HANDOVER;
        target_man_d = manual_on;
        hold_d       = '0;
      end
      ST_HANDOVER: begin
        // A change of mind restarts the full brake interval.
        if (manual_on != target_man_q) begin
          target_man_d = manual_on;
          hold_d       = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = target_man_q ? ST_MANUAL : ST_AUTO;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_MANUAL: begin
        if (!manual_on) begin
          state_d      = ST_HANDOVER;
          target_man_d = 1'b0;
          hold_d       = '0;
        end else if (man_valid) begin
          dir_d = man_dir;
        end else if (wd_expire) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: begin
        if (!manual_on) begin
          state_d      = ST_HANDOVER;
          target_man_d = 1'b0;
          hold_d       = '0;
        end else if (man_valid && (man_cmd == MAN_STOP)) begin
          state_d = ST_MANUAL;
        end
      end
      ST_AUTO: begin
        if (manual_on) begin
          state_d      = ST_HANDOVER;
          target_man_d = 1'b1;
          hold_d       = '0;
        end else begin
          dir_d = auto_dir_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with state_q.
    case (state_d)
      ST_MANUAL: begin
        en_d  = 1'b1;
        src_d = SRC_MANUAL;
        if (state_q != ST_MANUAL) dir_d = DIR_STOP;
        dir_d = obstacle_filter(dir_d, obs_active);
      end
      ST_AUTO: begin
        en_d  = 1'b1;
        src_d = SRC_AUTO;
        rdy_d = 1'b1;
        if (state_q != ST_AUTO) dir_d = DIR_STOP;
        dir_d = obstacle_filter(dir_d, obs_active);
      end
      ST_TIMEOUT: begin
        src_d   = SRC_MANUAL;
        fault_d = 1'b1;
        dir_d   = DIR_STOP;
      end
      default: dir_d = DIR_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      target_man_q <= 1'b0;
      hold_q       <= '0;
      dir_q        <= DIR_STOP;
      en_q         <= 1'b0;
      src_q        <= SRC_NONE;
      fault_q      <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_man_q <= target_man_d;
      hold_q       <= hold_d;
      dir_q        <= dir_d;
      en_q         <= en_d;
      src_q        <= src_d;
      fault_q      <= fault_d;
      rdy_q        <= rdy_d;
    end
  end

  assign drive_dir  = dir_q;
  assign drive_en   = en_q;
  assign src        = src_q;
  assign fault      = fault_q;
  assign auto_ready = rdy_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_arbiter
// Each vector holds the inputs for one clock cycle and the outputs expected
// right after the following rising edge. Expected outputs are queued when
// the inputs are driven and compared after the edge.
// -----------------------------------------------------------------------------
module tb_drive_arbiter;

  localparam int HOLD  = 4;
  localparam int TMO_C = 100;
`ifdef OBSTACLE_STOP_EN
  localparam bit OBS_EN = 1'b1;
`else
  localparam bit OBS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       manual_on = 1'b1;
  logic [7:0] man_cmd = 8'h00;
  logic       man_valid = 1'b0;
  logic [3:0] auto_dir = 4'd0;
  logic       auto_valid = 1'b0;
  logic       obstacle = 1'b0;
  logic       auto_ready;
  logic [3:0] drive_dir;
  logic       drive_en;
  logic [1:0] src;
  logic       fault;

  always #5 clk = ~clk;

  drive_arbiter #(
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO_C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .manual_on (manual_on),
    .man_cmd   (man_cmd),
    .man_valid (man_valid),
    .auto_dir  (auto_dir),
    .auto_valid(auto_valid),
    .auto_ready(auto_ready),
    .obstacle  (obstacle),
    .drive_dir (drive_dir),
    .drive_en  (drive_en),
    .src       (src),
    .fault     (fault)
  );

  typedef struct packed {
    logic [3:0] dir;
    logic       en;
    logic [1:0] src;
    logic       flt;
    logic       rdy;
  } out_t;

  typedef struct {
    string      tag;
    logic       mo;
    logic       mv;
    logic [7:0] mc;
    logic       av;
    logic [3:0] ad;
    logic       obs;
    out_t       exp;
  } vec_t;

  typedef struct {
    string tag;
    out_t  exp;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic out_t o(logic [3:0] d, logic en, logic [1:0] s, logic f, logic r);
    out_t x;
    x.dir = d; x.en = en; x.src = s; x.flt = f; x.rdy = r;
    return x;
  endfunction

  function automatic out_t ho();                  return o(4'd0, 1'b0, 2'd0, 1'b0, 1'b0); endfunction
  function automatic out_t man(logic [3:0] d);    return o(d,    1'b1, 2'd1, 1'b0, 1'b0); endfunction
  function automatic out_t aut(logic [3:0] d);    return o(d,    1'b1, 2'd2, 1'b0, 1'b1); endfunction
  function automatic out_t tmo();                 return o(4'd0, 1'b0, 2'd1, 1'b1, 1'b0); endfunction

  function automatic vec_t mk(string tag, logic mo, logic mv, logic [7:0] mc,
                              logic av, logic [3:0] ad, logic obs, out_t e);
    vec_t v;
    v.tag = tag; v.mo = mo; v.mv = mv; v.mc = mc;
    v.av = av; v.ad = ad; v.obs = obs; v.exp = e;
    return v;
  endfunction

  task automatic compare(input string tag, input out_t e);
    out_t a;
    a.dir = drive_dir; a.en = drive_en; a.src = src; a.flt = fault; a.rdy = auto_ready;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got dir=%0d en=%0d src=%0d fault=%0d rdy=%0d, want dir=%0d en=%0d src=%0d fault=%0d rdy=%0d",
               tag, a.dir, a.en, a.src, a.flt, a.rdy, e.dir, e.en, e.src, e.flt, e.rdy);
    end else begin
      $display("ok   %s: dir=%0d en=%0d src=%0d fault=%0d rdy=%0d",
               tag, a.dir, a.en, a.src, a.flt, a.rdy);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t s;
    @(negedge clk);
    manual_on  = v.mo;
    man_valid  = v.mv;
    man_cmd    = v.mc;
    auto_valid = v.av;
    auto_dir   = v.ad;
    obstacle   = v.obs;
    s.tag = v.tag;
    s.exp = v.exp;
    sb.push_back(s);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      s = sb.pop_front();
      compare(s.tag, s.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation still running at %0t, want finished", $time);
    $fatal(1, "time limit");
  end

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < HOLD; i++) tbl.push_back(mk("boot_ho", 1, 0, 8'h00, 0, 0, 0, ho()));
    tbl.push_back(mk("man_entry",  1, 0, 8'h00, 0, 0, 0, man(0)));
    tbl.push_back(mk("m_0A",       1, 1, 8'h0A, 0, 0, 0, man(1)));
    tbl.push_back(mk("m_hold1",    1, 0, 8'h00, 0, 0, 0, man(1)));
    tbl.push_back(mk("m_06",       1, 1, 8'h06, 0, 0, 0, man(7)));
    tbl.push_back(mk("m_hold7",    1, 0, 8'h00, 0, 0, 0, man(7)));
    tbl.push_back(mk("m_55",       1, 1, 8'h55, 0, 0, 0, man(0)));
    tbl.push_back(mk("m_03",       1, 1, 8'h03, 0, 0, 0, man(5)));
    tbl.push_back(mk("m_0C",       1, 1, 8'h0C, 0, 0, 0, man(8)));
    tbl.push_back(mk("m_09",       1, 1, 8'h09, 0, 0, 0, man(6)));
    tbl.push_back(mk("m_08",       1, 1, 8'h08, 0, 0, 0, man(4)));
    tbl.push_back(mk("m_02",       1, 1, 8'h02, 0, 0, 0, man(3)));
    tbl.push_back(mk("m_04",       1, 1, 8'h04, 0, 0, 0, man(2)));
    tbl.push_back(mk("m_00",       1, 1, 8'h00, 0, 0, 0, man(0)));
    tbl.push_back(mk("m_01",       1, 1, 8'h01, 0, 0, 0, man(1)));
    tbl.push_back(mk("m_obs_01",   1, 1, 8'h01, 0, 0, 1, man(OBS_EN ? 4'd0 : 4'd1)));
    tbl.push_back(mk("m_obs_04",   1, 1, 8'h04, 0, 0, 1, man(2)));
    tbl.push_back(mk("m_clr_01",   1, 1, 8'h01, 0, 0, 0, man(1)));
    // switch to auto together with a strobe: switch wins, byte dropped
    tbl.push_back(mk("sw_to_auto", 0, 1, 8'h04, 0, 0, 0, ho()));
    for (int i = 1; i < HOLD; i++) tbl.push_back(mk("ho_to_auto", 0, 0, 8'h00, 0, 0, 0, ho()));
    tbl.push_back(mk("auto_entry", 0, 0, 8'h00, 0, 0, 0, aut(0)));
    tbl.push_back(mk("a_4",        0, 0, 8'h00, 1, 4'd4,  0, aut(4)));
    tbl.push_back(mk("a_12",       0, 0, 8'h00, 1, 4'd12, 0, aut(0)));
    tbl.push_back(mk("a_1",        0, 0, 8'h00, 1, 4'd1,  0, aut(1)));
    tbl.push_back(mk("a_invalid",  0, 0, 8'h00, 0, 4'd1,  0, aut(0)));
    tbl.push_back(mk("a_8",        0, 0, 8'h00, 1, 4'd8,  0, aut(8)));
    tbl.push_back(mk("a_obs_5",    0, 0, 8'h00, 1, 4'd5,  1, aut(OBS_EN ? 4'd0 : 4'd5)));
    tbl.push_back(mk("a_obs_7",    0, 0, 8'h00, 1, 4'd7,  1, aut(7)));
    tbl.push_back(mk("a_6",        0, 0, 8'h00, 1, 4'd6,  0, aut(6)));
    tbl.push_back(mk("a_9",        0, 0, 8'h00, 1, 4'd9,  0, aut(0)));
    tbl.push_back(mk("a_3",        0, 0, 8'h00, 1, 4'd3,  0, aut(3)));
    // back to manual; auto_ready must drop with the state change
    tbl.push_back(mk("sw_to_man",  1, 0, 8'h00, 1, 4'd3, 0, ho()));
    tbl.push_back(mk("ho_cnt1",    1, 0, 8'h00, 0, 0, 0, ho()));
    tbl.push_back(mk("ho_cnt2",    1, 0, 8'h00, 0, 0, 0, ho()));
    tbl.push_back(mk("ho_flip0",   0, 0, 8'h00, 0, 0, 0, ho()));
    tbl.push_back(mk("ho_flip1",   1, 0, 8'h00, 0, 0, 0, ho()));
    for (int i = 1; i < HOLD; i++) tbl.push_back(mk("ho_restart", 1, 0, 8'h00, 0, 0, 0, ho()));
    tbl.push_back(mk("man_reentry", 1, 0, 8'h00, 0, 0, 0, man(0)));

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    compare("reset_state", ho());
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // ---------------- watchdog expiry ----------------
    apply(mk("wd_kick", 1, 1, 8'h01, 0, 0, 0, man(1)));
    for (int i = 1; i <= TMO_C; i++)
      apply(mk($sformatf("wd_idle%0d", i), 1, 0, 8'h00, 0, 0, 0,
               (i < TMO_C) ? man(1) : tmo()));
    apply(mk("tmo_ignore01", 1, 1, 8'h01, 0, 0, 0, tmo()));
    apply(mk("tmo_stay",     1, 0, 8'h00, 0, 0, 0, tmo()));
    apply(mk("tmo_rearm00",  1, 1, 8'h00, 0, 0, 0, man(0)));

    // ---------------- strobe in the expiry cycle wins ----------------
    for (int i = 1; i < TMO_C; i++)
      apply(mk($sformatf("race_idle%0d", i), 1, 0, 8'h00, 0, 0, 0, man(0)));
    apply(mk("wd_race", 1, 1, 8'h02, 0, 0, 0, man(3)));
    for (int i = 1; i <= TMO_C; i++)
      apply(mk($sformatf("wd2_idle%0d", i), 1, 0, 8'h00, 0, 0, 0,
               (i < TMO_C) ? man(3) : tmo()));

    // ---------------- leave TIMEOUT through manual_on ----------------
    apply(mk("tmo_exit", 0, 0, 8'h00, 0, 0, 0, ho()));
    for (int i = 1; i < HOLD; i++) apply(mk("ho_exit", 0, 0, 8'h00, 0, 0, 0, ho()));
    apply(mk("auto_again", 0, 0, 8'h00, 0, 0, 0, aut(0)));
    apply(mk("a_2",        0, 0, 8'h00, 1, 4'd2, 0, aut(2)));

    // ---------------- asynchronous reset in AUTO ----------------
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_reset", ho());
    @(posedge clk);
    #1;
    compare("reset_hold", ho());
    rst_n = 1'b1;
    for (int i = 0; i < HOLD; i++) apply(mk("post_rst_ho", 0, 0, 8'h00, 1, 4'd2, 0, ho()));
    apply(mk("post_rst_auto", 0, 0, 8'h00, 1, 4'd2, 0, aut(0)));
    apply(mk("post_rst_a2",   0, 0, 8'h00, 1, 4'd2, 0, aut(2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
